// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage behind the command decoder.
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/SLL) register their result on the
// accept edge. MUL runs an iterative shift-add engine for WIDTH edges.
// Results, flags and the destination tag are presented over valid/ready.
module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op_code,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [TAG_W-1:0] in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [TAG_W-1:0] out_dest,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  // Iteration counter value seen on the final (WIDTH-th) multiply edge.
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    HOLD     = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [TAG_W-1:0]     dest_q, dest_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  // Multiply engine state. The multiplicand is double width so it can be
  // shifted left without loss; the accumulator holds the full product.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]     mul_tag_q, mul_tag_d;

  logic                 accept;

  // Single-cycle ALU datapath results.
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [WIDTH:0]       sll_full;
  logic [WIDTH-1:0]     alu_y;
  logic                 alu_c;
  logic                 alu_v;
  logic                 alu_produces;

  // Accumulator value after the current multiply iteration.
  logic [2*WIDTH-1:0]   acc_sum;

  assign accept = in_valid && (state_q == IDLE);

  // Shared arithmetic: one extra bit captures carry-out, borrow, and the last
  // bit shifted out of the top (shamt of zero shifts a 0 into that bit).
  assign add_full = {1'b0, data_a} + {1'b0, data_b};
  assign sub_full = {1'b0, data_a} - {1'b0, data_b};
  assign sll_full = {1'b0, data_a} << data_b[SHAMT_W-1:0];

  // Result and flag selection for the single-cycle operations.
  always_comb begin
    alu_y        = '0;
    alu_c        = 1'b0;
    alu_v        = 1'b0;
    alu_produces = 1'b1;
    case (alu_op_code)
      OP_ADD: begin
        alu_y = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                (add_full[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
        alu_v = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                (sub_full[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_AND: alu_y = data_a & data_b;
      OP_OR:  alu_y = data_a | data_b;
      OP_XOR: alu_y = data_a ^ data_b;
      OP_SLL: begin
        alu_y = sll_full[WIDTH-1:0];
        alu_c = sll_full[WIDTH];
      end
      OP_MUL, OP_NOP: alu_produces = 1'b0;
      default:        alu_produces = 1'b0;
    endcase
  end

  // Add the shifted multiplicand when the current multiplier bit is set.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Next-state and datapath update for the IDLE / MUL_BUSY / HOLD controller.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    dest_d    = dest_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_tag_d = mul_tag_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_op_code == OP_MUL) begin
            mcand_d   = {{WIDTH{1'b0}}, data_a};
            mplier_d  = data_b;
            acc_d     = '0;
            cnt_d     = '0;
            mul_tag_d = in_dest;
            state_d   = MUL_BUSY;
          end else if (alu_produces) begin
            y_d     = alu_y;
            zero_d  = (alu_y == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            dest_d  = in_dest;
            valid_d = 1'b1;
            state_d = HOLD;
          end
          // NOP: consumed, nothing changes.
        end
      end

      MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_sum[WIDTH-1:0];
          zero_d  = (acc_sum[WIDTH-1:0] == '0);
          carry_d = (acc_sum[2*WIDTH-1:WIDTH] != '0);
          ovf_d   = 1'b0;
          dest_d  = mul_tag_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      dest_q    <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mul_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      dest_q    <= dest_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mul_tag_q <= mul_tag_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == MUL_BUSY);
  assign out_valid  = valid_q;
  assign y          = y_q;
  assign out_dest   = dest_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, ALU ops, flags, MUL latency,
// backpressure, NOP and reset during a multiply.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op_code;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [2:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [2:0]  out_dest;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_ovf;
  logic        busy;

  int tests;
  int failed;

  alu_exec_stage #(.WIDTH(32), .SHAMT_W(5), .TAG_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op_code(alu_op_code),
    .data_a     (data_a),
    .data_b     (data_b),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .out_dest   (out_dest),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample/drive 1 time unit afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge (DUT must be in IDLE).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] dest);
    in_valid    = 1'b1;
    alu_op_code = op;
    data_a      = a;
    data_b      = b;
    in_dest     = dest;
    tick();
    in_valid    = 1'b0;
    data_a      = 32'hDEAD_BEEF;
    data_b      = 32'h1234_5678;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] ey, input logic ez,
                              input logic ec, input logic ev, input logic [2:0] ed);
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, ".y"}, 64'(y), 64'(ey));
    check({tag, ".zero"}, 64'(flag_zero), 64'(ez));
    check({tag, ".carry"}, 64'(flag_carry), 64'(ec));
    check({tag, ".ovf"}, 64'(flag_ovf), 64'(ev));
    check({tag, ".dest"}, 64'(out_dest), 64'(ed));
    $display("[TB] %s y=%08h z=%0b c=%0b v=%0b dest=%0d", tag, y, flag_zero, flag_carry,
             flag_ovf, out_dest);
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    alu_op_code = 3'b000;
    data_a      = '0;
    data_b      = '0;
    in_dest     = '0;
    out_ready   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.valid", 64'(out_valid), 64'(1'b0));
    check("rst.y", 64'(y), 64'h0);
    check("rst.dest", 64'(out_dest), 64'h0);
    check("rst.flags", 64'({flag_zero, flag_carry, flag_ovf}), 64'(3'b000));
    check("rst.busy", 64'(busy), 64'(1'b0));
    rst = 1'b0;
    tick();
    check("rst.in_ready", 64'(in_ready), 64'(1'b1));

    // ADD with carry-out wrapping to zero
    issue(3'b000, 32'hFFFF_FFFF, 32'h1, 3'd3);
    check_result("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 3'd3);
    check("add_wrap.in_ready", 64'(in_ready), 64'(1'b0));
    release_out();
    check("add_wrap.rel_valid", 64'(out_valid), 64'(1'b0));
    check("add_wrap.rel_in_ready", 64'(in_ready), 64'(1'b1));
    check("add_wrap.rel_y", 64'(y), 64'h0);

    // Signed overflow on ADD, borrow on SUB
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 3'd1);
    check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 3'd1);
    release_out();
    issue(3'b001, 32'h1, 32'h2, 3'd2);
    check_result("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 3'd2);
    release_out();
    issue(3'b001, 32'h8000_0000, 32'h1, 3'd4);
    check_result("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 3'd4);
    release_out();

    // Logic ops
    issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6);
    check_result("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0, 3'd6);
    release_out();
    issue(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7);
    check_result("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 3'd7);
    release_out();

    // SLL: upper bits of b ignored, carry = last bit out; shamt 0 passes a
    issue(3'b101, 32'h8000_0001, 32'h0000_0021, 3'd1);
    check_result("sll1", 32'h0000_0002, 1'b0, 1'b1, 1'b0, 3'd1);
    release_out();
    issue(3'b101, 32'h8000_0001, 32'h0, 3'd2);
    check_result("sll0", 32'h8000_0001, 1'b0, 1'b0, 1'b0, 3'd2);
    release_out();

    // MUL with product overflowing the low word: result at accept edge + 32
    issue(3'b110, 32'h0001_0000, 32'h0001_0000, 3'd5);
    check("mul1.busy", 64'(busy), 64'(1'b1));
    check("mul1.in_ready", 64'(in_ready), 64'(1'b0));
    check("mul1.valid_early", 64'(out_valid), 64'(1'b0));
    for (int i = 0; i < 30; i++) tick();
    check("mul1.valid_at31", 64'(out_valid), 64'(1'b0));
    tick();
    check("mul1.busy_at31", 64'(busy), 64'(1'b1));
    tick();
    check("mul1.busy_done", 64'(busy), 64'(1'b0));
    check_result("mul1", 32'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    release_out();

    issue(3'b110, 32'd7, 32'd6, 3'd3);
    for (int i = 0; i < 32; i++) tick();
    check_result("mul_7x6", 32'd42, 1'b0, 1'b0, 1'b0, 3'd3);
    release_out();

    // Backpressure: result held, competing request ignored
    issue(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5);
    in_valid    = 1'b1;
    alu_op_code = 3'b000;
    data_a      = 32'd1;
    data_b      = 32'd1;
    in_dest     = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_result("bp_hold", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 3'd5);
      check("bp.in_ready", 64'(in_ready), 64'(1'b0));
    end
    in_valid = 1'b0;
    release_out();
    check("bp.rel_valid", 64'(out_valid), 64'(1'b0));
    check("bp.rel_y", 64'(y), 64'h0FF0_0FF0);

    // NOP consumed without output
    issue(3'b111, 32'h5, 32'h5, 3'd2);
    check("nop.valid", 64'(out_valid), 64'(1'b0));
    check("nop.in_ready", 64'(in_ready), 64'(1'b1));
    check("nop.y", 64'(y), 64'h0FF0_0FF0);
    check("nop.dest", 64'(out_dest), 64'(3'd5));

    // Reset during a multiply (iteration 10), then ADD with latency 1
    issue(3'b110, 32'd3, 32'd5, 3'd4);
    for (int i = 0; i < 9; i++) tick();
    check("midmul.busy", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    #1;
    check("midmul.rst_valid", 64'(out_valid), 64'(1'b0));
    check("midmul.rst_busy", 64'(busy), 64'(1'b0));
    check("midmul.rst_y", 64'(y), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("midmul.in_ready", 64'(in_ready), 64'(1'b1));
    issue(3'b000, 32'd2, 32'd3, 3'd2);
    check_result("post_rst_add", 32'd5, 1'b0, 1'b0, 1'b0, 3'd2);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
